// File: rtl/pipeline_pkg.sv
// Shared opcode encodings, sequencer states and decode-source helpers for the
// 4-bit-opcode core pipeline control logic.
package pipeline_pkg;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_B    = 4'b0001;
  localparam logic [3:0] OP_BEQ  = 4'b0010;
  localparam logic [3:0] OP_BLT  = 4'b0011;
  localparam logic [3:0] OP_LDW  = 4'b0100;
  localparam logic [3:0] OP_LDB  = 4'b0101;
  localparam logic [3:0] OP_STW  = 4'b0110;
  localparam logic [3:0] OP_STB  = 4'b0111;
  localparam logic [3:0] OP_ADD  = 4'b1000;
  localparam logic [3:0] OP_ADDI = 4'b1001;
  localparam logic [3:0] OP_SUB  = 4'b1010;
  localparam logic [3:0] OP_DIV  = 4'b1011;
  localparam logic [3:0] OP_SHL  = 4'b1100;

  typedef enum logic {
    RUN      = 1'b0,
    DIV_WAIT = 1'b1
  } seq_state_e;

  function automatic logic uses_rm(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_DIV, OP_SHL,
      OP_STW, OP_STB, OP_BEQ, OP_BLT: uses_rm = 1'b1;
      default:                        uses_rm = 1'b0;
    endcase
  endfunction

  // Every instruction reading Rm also reads Rn; immediates and loads read Rn only.
  function automatic logic uses_rn(input logic [3:0] op);
    case (op)
      OP_ADDI, OP_LDW, OP_LDB: uses_rn = 1'b1;
      default:                 uses_rn = uses_rm(op);
    endcase
  endfunction

  function automatic logic is_branch(input logic [3:0] op);
    is_branch = (op == OP_B) || (op == OP_BEQ) || (op == OP_BLT);
  endfunction

  function automatic logic is_load(input logic [3:0] op);
    is_load = (op == OP_LDW) || (op == OP_LDB);
  endfunction

endpackage

// File: rtl/hazard_sequencer_stall_counter.sv
// Loadable 8-bit down-counter that times the divider hold; load wins over dec.
module stall_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       dec,
  output logic [7:0] cnt,
  output logic       zero
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != 8'd0)) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == 8'd0);

endmodule

// File: rtl/hazard_sequencer.sv
// Stall/flush sequencer for the F/D/E/M pipeline: taken-branch flush,
// load-use bubble and multi-cycle divide hold. Outputs are Mealy.
module hazard_sequencer
  import pipeline_pkg::*;
#(
  parameter int unsigned RA_W       = 4,
  parameter int unsigned DIV_CYCLES = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      D_OpCode,
  input  logic [RA_W-1:0] D_Rn,
  input  logic [RA_W-1:0] D_Rm,
  input  logic [3:0]      E_OpCode,
  input  logic [RA_W-1:0] E_Rd,
  input  logic            E_BranchTaken,
  output logic            StallF,
  output logic            StallD,
  output logic            StallE,
  output logic            FlushD,
  output logic            FlushE,
  output logic            FlushM,
  output logic            DivStart,
  output logic            DivBusy,
  output logic            DivResultValid
);

  localparam logic [7:0] CNT_LOAD = 8'(DIV_CYCLES - 1);

  seq_state_e state_q;
  seq_state_e state_d;

  logic       cnt_load;
  logic       cnt_dec;
  logic [7:0] cnt;
  logic       cnt_zero;
  logic       load_use;

  stall_counter u_stall_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (CNT_LOAD),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  assign load_use = is_load(E_OpCode) &&
                    ((uses_rn(D_OpCode) && (D_Rn == E_Rd)) ||
                     (uses_rm(D_OpCode) && (D_Rm == E_Rd)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_load       = 1'b0;
    cnt_dec        = 1'b0;
    StallF         = 1'b0;
    StallD         = 1'b0;
    StallE         = 1'b0;
    FlushD         = 1'b0;
    FlushE         = 1'b0;
    FlushM         = 1'b0;
    DivStart       = 1'b0;
    DivBusy        = 1'b0;
    DivResultValid = 1'b0;

    case (state_q)
      RUN: begin
        if (E_OpCode == OP_DIV) begin
          DivStart = 1'b1;
          StallF   = 1'b1;
          StallD   = 1'b1;
          StallE   = 1'b1;
          FlushM   = 1'b1;
          cnt_load = 1'b1;
          state_d  = DIV_WAIT;
        end else if (is_branch(E_OpCode) && E_BranchTaken) begin
          // A simultaneous load-use is moot: the D instruction is being discarded.
          FlushD = 1'b1;
          FlushE = 1'b1;
        end else if (load_use) begin
          StallF = 1'b1;
          StallD = 1'b1;
          FlushE = 1'b1;
        end
      end
      DIV_WAIT: begin
        DivBusy = 1'b1;
        if (!cnt_zero) begin
          StallF  = 1'b1;
          StallD  = 1'b1;
          StallE  = 1'b1;
          FlushM  = 1'b1;
          cnt_dec = 1'b1;
        end else begin
          DivResultValid = 1'b1;
          state_d        = RUN;
        end
      end
      default: state_d = RUN;
    endcase

    // Outputs are Mealy, so force them quiet while reset is held.
    if (!rst_n) begin
      state_d        = RUN;
      cnt_load       = 1'b0;
      cnt_dec        = 1'b0;
      StallF         = 1'b0;
      StallD         = 1'b0;
      StallE         = 1'b0;
      FlushD         = 1'b0;
      FlushE         = 1'b0;
      FlushM         = 1'b0;
      DivStart       = 1'b0;
      DivBusy        = 1'b0;
      DivResultValid = 1'b0;
    end
  end

endmodule

// File: doc/hazard_sequencer.md
Name: hazard_sequencer

Overview:
- Pipeline sequencing controller for the 4-bit-opcode core.
- Generates stall and flush controls for the F/D/E/M pipeline registers.
- Covers three cases: taken-branch flush, load-use bubble, and multi-cycle divide hold.
- Sits beside the decoder. Consumes decode- and execute-stage opcodes and register indices, and drives the pipeline-register enables/clears and the iterative divider's start pulse.

Parameters:
- RA_W, 4, register-address width.
- DIV_CYCLES, 8, divider iterations after start; legal range 1..255.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- D_OpCode  in  4  opcode in decode stage
- D_Rn  in  RA_W  decode source register 1
- D_Rm  in  RA_W  decode source register 2
- E_OpCode  in  4  opcode in execute stage
- E_Rd  in  RA_W  execute destination register
- E_BranchTaken  in  1  branch resolved taken in E (valid only when E_OpCode is 0001/0010/0011)
- StallF  out  1  hold PC/fetch register
- StallD  out  1  hold F/D register
- StallE  out  1  hold D/E register
- FlushD  out  1  clear F/D register to NOP
- FlushE  out  1  clear D/E register to NOP
- FlushM  out  1  clear E/M register to NOP
- DivStart  out  1  one-cycle divider start pulse
- DivBusy  out  1  divider iterating
- DivResultValid  out  1  divider result valid this cycle; E/M register captures it

Behaviour:
- Opcodes:
  - 0000 NOP; 0001 B; 0010 BEQ; 0011 BLT
  - 0100 LDW; 0101 LDB; 0110 STW; 0111 STB
  - 1000 ADD; 1001 ADDI; 1010 SUB; 1011 DIV; 1100 SHL
  - 1101-1111 undefined, treated as NOP.
- Decode source usage:
  - Both Rn and Rm: ADD, SUB, DIV, SHL, STW, STB, BEQ, BLT.
  - Rn only: ADDI, LDW, LDB.
  - None: NOP, B, undefined.
- States: RUN, DIV_WAIT. 8-bit down-counter cnt.
- Reset (rst_n low, async):
  - state=RUN, cnt=0.
  - All outputs 0 while rst_n low, regardless of inputs.
  - Reset mid-divide aborts it; no DivResultValid is issued.
- Outputs are Mealy: combinational from state, cnt and inputs. State and cnt are registered.
- RUN, evaluated in priority order:
  1. E_OpCode=DIV:
     - DivStart=1, StallF=StallD=StallE=1, FlushM=1.
     - Next state DIV_WAIT, cnt<=DIV_CYCLES-1.
  2. E is a branch and E_BranchTaken=1:
     - FlushD=1, FlushE=1, no stalls.
     - Any load-use condition in the same cycle is ignored; the flushed instruction would have been discarded anyway.
  3. Load-use:
     - Condition: E_OpCode in {LDW, LDB} and (D_Rn==E_Rd where D uses Rn, or D_Rm==E_Rd where D uses Rm).
     - Response: StallF=StallD=1, FlushE=1 for exactly one cycle.
     - The next cycle re-evaluates with the load in M, so no further stall follows.
  4. Otherwise all outputs 0.
- DIV_WAIT:
  - DivBusy=1 throughout.
  - cnt!=0: StallF=StallD=StallE=1, FlushM=1, cnt<=cnt-1.
  - cnt==0:
    - All stalls and flushes 0, DivResultValid=1, next state RUN.
    - The pipeline advances at the end of this cycle.
    - There is no restart: a DIV is only recognised in state RUN.
  - Branch and load-use inputs are ignored; E holds the DIV.
- Timing: a DIV occupies E for DIV_CYCLES+1 cycles (start cycle plus DIV_CYCLES wait cycles).
- Back-to-back DIVs: the second reaches E in the cycle after release (state RUN) and starts normally.
- DIV_CYCLES=1: one DIV_WAIT cycle, with cnt==0 on entry.
- Register index 0 is not special; a match on R0 still stalls.
- Mutual exclusion: DivStart, the branch flush and the load-use stall are exclusive by construction, since E holds one opcode.

Decomposition:
- Package pipeline_pkg:
  - 4-bit opcode localparams (OP_NOP through OP_SHL).
  - State enum {RUN, DIV_WAIT}.
  - Functions uses_rn(op) and uses_rm(op).
- Sub-module stall_counter:
  - Loadable 8-bit down-counter.
  - Inputs clk, rst_n, load, load_val, dec. Outputs cnt, zero.

Test Plan:
- Reset check: assert rst_n=0 while E_OpCode=DIV -> all outputs 0. Release reset -> DivStart on the first clk edge observed in RUN.
- DIV with DIV_CYCLES=8: E_OpCode=1011 held while stalled ->
  - DivStart=1 on cycle 0.
  - DivBusy=1 on cycles 1-8; StallE=1 on cycles 0-7.
  - DivResultValid=1 only on cycle 8.
  - State RUN on cycle 9.
- Load-use: E=LDW with E_Rd=3; D=ADD with D_Rn=5, D_Rm=3 -> StallF=StallD=FlushE=1 for one cycle. With D=ADDI, D_Rm=3, D_Rn=5 -> no stall.
- Taken branch: E=BEQ, E_BranchTaken=1, plus a simultaneous load-use pattern in D -> FlushD=FlushE=1, StallF=0. With E_BranchTaken=0 -> no flush.
- Back-to-back DIV: two DIVs, DIV_CYCLES=2 -> two DivStart pulses exactly 3 cycles apart, and two DivResultValid pulses.
- Reset mid-divide: pulse rst_n low during DIV_WAIT with cnt=4 -> DivBusy drops immediately and no DivResultValid is issued. After release, a NOP in E -> all outputs 0.
